regfile: RTL and testbench



---
 rtl/regfile_if.sv | 23 ++
 rtl/regfile.sv | 29 ++
 tb/tb_regfile.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Register-file access bundle: decode drives addresses/write controls, the file returns read data.
interface regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_or_w;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;

    modport master (
        output r_addr1, r_addr2, w_addr, w_data, r_or_w,
        input  data1, data2
    );

    modport slave (
        input  r_addr1, r_addr2, w_addr, w_data, r_or_w,
        output data1, data2
    );
endinterface

// File: rtl/regfile.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one write port (1-edge latency).
// No backpressure; reset clears all entries and takes priority over a same-edge write.
module regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    regfile_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // Declaration initialiser gives the zero power-up state without a reset edge.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.r_or_w) begin
            r_mem[bus.w_addr] <= bus.w_data;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the pre-edge contents.
    assign bus.data1 = r_mem[bus.r_addr1];
    assign bus.data2 = r_mem[bus.r_addr2];
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile against an array model of the register contents.
module tb_regfile;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] mdl [8];

    // One rising edge; the model applies the architectural rule for that edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        end else if (bus.r_or_w) begin
            mdl[bus.w_addr] = bus.w_data;
        end
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        bus.w_addr = a;
        bus.w_data = d;
        bus.r_or_w = 1'b1;
        step();
        bus.r_or_w = 1'b0;
    endtask

    task automatic test_powerup();
        for (int i = 0; i < 8; i++) begin
            bus.r_addr1 = 3'(i);
            bus.r_addr2 = 3'(7 - i);
            #1;
            tests++;
            if (bus.data1 !== 8'h00 || bus.data2 !== 8'h00) begin
                fails++;
                $display("FAIL powerup addr=%0d data1=%h data2=%h expected 00/00", i, bus.data1, bus.data2);
            end
        end
    endtask

    task automatic test_reset();
        write_reg(3'd6, 8'h5A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.r_addr1 = 3'(i);
            bus.r_addr2 = 3'(i ^ 3);
            #1;
            tests++;
            if (bus.data1 !== 8'h00 || bus.data2 !== 8'h00) begin
                fails++;
                $display("FAIL reset addr=%0d data1=%h data2=%h expected 00/00", i, bus.data1, bus.data2);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(3'd2, 8'd63);
        bus.r_addr1 = 3'd2;
        bus.r_addr2 = 3'd1;
        #1;
        tests++;
        if (bus.data1 !== 8'b00111111 || bus.data2 !== 8'h00) begin
            fails++;
            $display("FAIL write_read data1=%0d data2=%0d expected 63/0", bus.data1, bus.data2);
        end
        write_reg(3'd4, 8'd31);
        bus.r_addr1 = 3'd4;
        bus.r_addr2 = 3'd2;
        #1;
        tests++;
        if (bus.data1 !== 8'b00011111 || bus.data2 !== 8'd63) begin
            fails++;
            $display("FAIL preserve data1=%0d data2=%0d expected 31/63", bus.data1, bus.data2);
        end
    endtask

    task automatic test_gating();
        bus.r_or_w = 1'b0;
        bus.w_addr = 3'd4;
        bus.w_data = 8'd200;
        repeat (4) step();
        bus.r_addr1 = 3'd4;
        bus.r_addr2 = 3'd2;
        #1;
        tests++;
        if (bus.data1 !== 8'd31 || bus.data2 !== 8'd63) begin
            fails++;
            $display("FAIL gating data1=%0d data2=%0d expected 31/63", bus.data1, bus.data2);
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        bus.r_or_w = 1'b1;
        bus.w_addr = 3'd5;
        bus.w_data = 8'hAA;
        step();
        reset = 1'b0;
        bus.r_or_w = 1'b0;
        bus.r_addr1 = 3'd5;
        bus.r_addr2 = 3'd2;
        #1;
        tests++;
        if (bus.data1 !== 8'h00 || bus.data2 !== 8'h00) begin
            fails++;
            $display("FAIL reset_priority r5=%h r2=%h expected 00/00", bus.data1, bus.data2);
        end
        bus.r_addr1 = 3'd4;
        #1;
        tests++;
        if (bus.data1 !== 8'h00) begin
            fails++;
            $display("FAIL reset_priority r4=%h expected 00", bus.data1);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] old_v;
        old_v = mdl[3];
        bus.r_addr1 = 3'd3;
        bus.r_addr2 = 3'd3;
        bus.w_addr  = 3'd3;
        bus.w_data  = 8'hC3;
        bus.r_or_w  = 1'b1;
        #1;
        tests++;
        if (bus.data1 !== old_v || bus.data2 !== old_v) begin
            fails++;
            $display("FAIL same_cycle_before data1=%h data2=%h expected %h", bus.data1, bus.data2, old_v);
        end
        step();
        bus.r_or_w = 1'b0;
        tests++;
        if (bus.data1 !== 8'hC3 || bus.data2 !== 8'hC3) begin
            fails++;
            $display("FAIL same_cycle_after data1=%h data2=%h expected c3", bus.data1, bus.data2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            bus.w_addr = 3'(i);
            bus.w_data = 8'hF0 | 8'(i);
            bus.r_or_w = 1'b1;
            step();
        end
        bus.r_or_w = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                bus.r_addr1 = 3'(a);
                bus.r_addr2 = 3'(b);
                #1;
                tests++;
                if (bus.data1 !== (8'hF0 | 8'(a)) || bus.data2 !== (8'hF0 | 8'(b))) begin
                    fails++;
                    $display("FAIL sweep a=%0d b=%0d data1=%h data2=%h", a, b, bus.data1, bus.data2);
                end
                if (a == b) begin
                    tests++;
                    if (bus.data1 !== bus.data2) begin
                        fails++;
                        $display("FAIL sweep_same a=%0d data1=%h data2=%h", a, bus.data1, bus.data2);
                    end
                end
            end
        end
        // Last write to an address wins.
        write_reg(3'd1, 8'h11);
        write_reg(3'd1, 8'h22);
        bus.r_addr1 = 3'd1;
        #1;
        tests++;
        if (bus.data1 !== 8'h22) begin
            fails++;
            $display("FAIL last_write_wins data1=%h expected 22", bus.data1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 19) == 0);
            bus.r_or_w  = 1'($urandom_range(0, 1));
            bus.w_addr  = 3'($urandom_range(0, 7));
            bus.w_data  = 8'($urandom_range(0, 255));
            bus.r_addr1 = 3'($urandom_range(0, 7));
            bus.r_addr2 = 3'($urandom_range(0, 7));
            #1;
            tests++;
            if (bus.data1 !== mdl[bus.r_addr1] || bus.data2 !== mdl[bus.r_addr2]) begin
                fails++;
                $display("FAIL random n=%0d a1=%0d a2=%0d data1=%h data2=%h expected %h/%h",
                         n, bus.r_addr1, bus.r_addr2, bus.data1, bus.data2,
                         mdl[bus.r_addr1], mdl[bus.r_addr2]);
            end
            step();
        end
        reset = 1'b0;
        bus.r_or_w = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        bus.r_addr1 = '0;
        bus.r_addr2 = '0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        bus.r_or_w  = 1'b0;
        #2;
        test_powerup();
        test_reset();
        test_write_read();
        test_gating();
        test_reset_priority();
        test_same_cycle();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
